seq_detect_sched: RTL
=====================

// Module: seq_detect_sched
// PURPOSE
//  Shares one overlapping serial pattern matcher between N_CH bit-serial input channels.
//  A round-robin scheduler grants one channel per cycle and consumes that channel's bit.
//  Each channel keeps its own match history, so streams never corrupt each other.
//  Sits between the serial front-ends and the event/interrupt logic; reports which channel hit.
// PARAMETERS
//  N_CH     4        number of serial requesters (2..16)
//  PAT_W    4        pattern length in bits (2..8)
//  PATTERN  4'b1011  pattern matched MSB-first (first-received bit = MSB); overlapping matches allowed
//  CNT_W    8        width of per-channel hit counters (HIT_CNT_EN only)
// PORTS
//  clk       in   1            single clock, rising edge
//  rst_n     in   1            asynchronous active-low reset
//  ch_valid  in   N_CH         channel i offers bit ch_bit[i]
//  ch_bit    in   N_CH         serial data bit per channel
//  ch_flush  in   N_CH         synchronous per-channel history clear
//  ch_ready  out  N_CH         one-hot grant (combinational); transfer = ch_valid[i] & ch_ready[i]
//  hit_valid out  1            registered pulse: the previous transfer completed PATTERN
//  hit_ch    out  $clog2(N_CH) channel that produced the hit; valid only with hit_valid
//  cnt_sel   in   $clog2(N_CH) hit-counter read select (HIT_CNT_EN only)
//  cnt_out   out  CNT_W        hit count of channel cnt_sel (HIT_CNT_EN only)
// BEHAVIOUR
//  Reset (async, rst_n=0): rr_ptr=0; all hist=0; all fill=0; hit_valid=0; hit_ch=0; counters=0.
//   ch_ready depends only on ch_valid and rr_ptr, so it is 0 while every ch_valid is 0.
//  Arbitration: scan channels rr_ptr, rr_ptr+1, ... (mod N_CH); grant the first with ch_valid=1.
//   At most one bit of ch_ready is high. With no valid channel, ch_ready=0.
//   On a transfer to channel g, rr_ptr <= (g+1) mod N_CH. With no transfer, rr_ptr holds.
//   Fairness: a channel holding ch_valid high is granted within N_CH cycles.
//  Per-channel context: hist[i] holds the last PAT_W-1 bits. fill[i] counts 0..PAT_W-1 and saturates.
//  Transfer on channel g with bit b:
//   - match = (fill[g]==PAT_W-1) && ({hist[g],b}==PATTERN)
//   - hist[g] <= {hist[g][PAT_W-3:0], b}; fill[g] <= min(fill[g]+1, PAT_W-1)
//   - next cycle: hit_valid=match and hit_ch=g. Latency is exactly 1 clk.
//   - Overlap is handled inherently: for 1011, the stream 1011011 gives hits on bits 4 and 7.
//  No transfer: hit_valid=0 next cycle; hit_ch holds its last value.
//  Flush: ch_flush[i] sets hist[i]=0 and fill[i]=0 next cycle.
//   If the flush coincides with a transfer on channel i, the flush wins. The bit is still consumed:
//   it becomes the first history bit (fill=1, hist LSB=b) and match is forced to 0.
//   ch_flush does not affect arbitration or the counters.
//  Reset asserted mid-stream: all contexts are lost immediately, and any pending hit_valid drops at once.
//   After rst_n deasserts, each channel needs PAT_W fresh bits before it can hit.
//  Idle channels keep their context indefinitely; history spans arbitrarily long gaps.
// CONFIGURATION
//  HIT_CNT_EN defined: per-channel CNT_W-bit counters increment on each hit of that channel.
//   The counters saturate at all-ones and are cleared only by reset, not by ch_flush.
//   cnt_out = count[cnt_sel], combinational.
//  HIT_CNT_EN undefined: no counters; cnt_out is tied to 0; cnt_sel is ignored.
// STRUCTURE
//  Package seq_sched_pkg holds:
//   - the default PATTERN constant
//   - a log2 function for the index widths
//   - a typedef for the per-channel context {hist, fill}
//  Sub-module rr_arbiter #(N): inputs req and ptr; outputs one-hot gnt and binary gnt_idx.
//   It is purely combinational and reused for ch_ready.
//  Top level holds rr_ptr, the context register array, the match compare, the hit registers and the optional counters.
// TESTING
//  1. Reset, then ch0 only sends 1,0,1,1,0,1,1 -> hit_valid=1 with hit_ch=0 the cycle after bits 4 and 7 only.
//  2. All 4 ch_valid held high -> ch_ready cycles 0001,0010,0100,1000,0001. No channel is starved.
//  3. Interleave ch1 sends 1,0,1 and ch2 sends 0,0; then ch1 sends 1 -> a single hit with hit_ch=1. The ch2 bits do not disturb ch1.
//  4. ch3 has received 1,0,1; assert ch_flush[3] together with bit 1 -> no hit. Then 0,1,1 -> hit_ch=3.
//  5. Pulse rst_n low after 3 matching bits of ch0 -> all outputs are 0 at once. Sending 1 after release -> no hit.
//  6. HIT_CNT_EN with CNT_W=2: 5 hits on ch2, cnt_sel=2 -> cnt_out=3 (saturated); cnt_sel=0 -> 0.

Source files
------------

// File: rtl/seq_sched_pkg.sv
// Shared definitions for the multi-channel serial pattern detector:
// default pattern, index-width helper and the per-channel context record.
package seq_sched_pkg;

  // Pattern used when the instantiating level does not override PATTERN.
  localparam logic [3:0] DEFAULT_PATTERN = 4'b1011;

  // Context fields are sized for the largest supported pattern (8 bits),
  // so one record type serves every PAT_W; unused high history bits stay 0.
  localparam int HIST_MAX = 7;
  localparam int FILL_W   = 3;

  // Per-channel match history: last PAT_W-1 bits plus how many are valid.
  typedef struct packed {
    logic [HIST_MAX-1:0] hist;
    logic [FILL_W-1:0]   fill;
  } ch_ctx_t;

  // Index width for n entries, never below 1 bit.
  function automatic int sched_log2(input int n);
    for (int w = 1; w < 31; w++) begin
      if ((1 << w) >= n) return w;
    end
    return 31;
  endfunction

endpackage

// File: rtl/seq_detect_sched_rr_arbiter.sv
// Combinational round-robin arbiter: scans req starting at ptr and grants
// the first requester found. Produces a one-hot grant and its binary index.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx
);

  int unsigned idx;
  logic        found;

  // Priority scan from ptr upward, wrapping modulo N.
  always_comb begin
    // NOTE: every variable gets a default before the loop so no path leaves
    // it unassigned; otherwise synthesis would infer a latch.
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        found        = 1'b1;
        gnt[idx]     = 1'b1;
        gnt_idx      = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/seq_detect_sched.sv
// Shared overlapping serial pattern matcher for N_CH bit-serial channels.
// A round-robin grant picks one channel per cycle; its bit is matched
// against that channel's own history, and a hit is reported one clock later.
// Optional feature macro: HIT_CNT_EN adds saturating per-channel hit
// counters readable through cnt_sel/cnt_out (tied to 0 when undefined).
module seq_detect_sched
  import seq_sched_pkg::*;
#(
  parameter int                N_CH    = 4,
  parameter int                PAT_W   = 4,
  parameter logic [PAT_W-1:0]  PATTERN = PAT_W'(DEFAULT_PATTERN),
  parameter int                CNT_W   = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_CH-1:0]               ch_valid,
  input  logic [N_CH-1:0]               ch_bit,
  input  logic [N_CH-1:0]               ch_flush,
  output logic [N_CH-1:0]               ch_ready,
  output logic                          hit_valid,
  output logic [sched_log2(N_CH)-1:0]   hit_ch,
  input  logic [sched_log2(N_CH)-1:0]   cnt_sel,
  output logic [CNT_W-1:0]              cnt_out
);

  localparam int                  IDX_W     = sched_log2(N_CH);
  localparam int                  EXT_W     = HIST_MAX + 1;
  localparam logic [HIST_MAX-1:0] HIST_MASK = HIST_MAX'((1 << (PAT_W - 1)) - 1);
  localparam logic [FILL_W-1:0]   FILL_FULL = FILL_W'(PAT_W - 1);
  localparam logic [EXT_W-1:0]    PAT_EXT   = EXT_W'(PATTERN);

  logic [N_CH-1:0]  gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             xfer;

  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  ch_ctx_t          ctx_q [N_CH];
  ch_ctx_t          ctx_d [N_CH];
  logic             hit_valid_q, hit_valid_d;
  logic [IDX_W-1:0] hit_ch_q, hit_ch_d;

  logic             gnt_bit;
  ch_ctx_t          gnt_ctx;
  logic             match;

  rr_arbiter #(
    .N     (N_CH),
    .IDX_W (IDX_W)
  ) u_arb (
    .req     (ch_valid),
    .ptr     (rr_ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign ch_ready  = gnt;
  assign xfer      = |gnt;
  assign hit_valid = hit_valid_q;
  assign hit_ch    = hit_ch_q;

  // Compare the granted channel's history plus the incoming bit to PATTERN.
  // High history bits are always 0, so a zero-extended compare is exact.
  always_comb begin
    // NOTE: combinational logic uses blocking '=' so later statements see
    // earlier results; clocked state below uses non-blocking '<='.
    gnt_bit = ch_bit[gnt_idx];
    gnt_ctx = ctx_q[gnt_idx];
    match   = xfer && !ch_flush[gnt_idx] &&
              (gnt_ctx.fill == FILL_FULL) &&
              ({gnt_ctx.hist, gnt_bit} == PAT_EXT);
  end

  // Next-state context per channel: shift on transfer, clear on flush; a
  // flushed channel that is also granted keeps the new bit as its first.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      ctx_d[i] = ctx_q[i];
      if (ch_flush[i]) begin
        if (xfer && (gnt_idx == IDX_W'(i))) begin
          ctx_d[i].hist = HIST_MAX'(gnt_bit);
          ctx_d[i].fill = FILL_W'(1);
        end else begin
          ctx_d[i] = '0;
        end
      end else if (xfer && (gnt_idx == IDX_W'(i))) begin
        ctx_d[i].hist = {ctx_q[i].hist[HIST_MAX-2:0], gnt_bit} & HIST_MASK;
        ctx_d[i].fill = (ctx_q[i].fill == FILL_FULL) ? ctx_q[i].fill
                                                     : ctx_q[i].fill + FILL_W'(1);
      end
    end
  end

  // Pointer advances past the granted channel; hit registers follow a transfer.
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    hit_ch_d    = hit_ch_q;
    hit_valid_d = match;
    if (xfer) begin
      rr_ptr_d = (gnt_idx == IDX_W'(N_CH - 1)) ? '0 : gnt_idx + IDX_W'(1);
      hit_ch_d = gnt_idx;
    end
  end

  // State registers: pointer, channel contexts and the hit report.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q    <= '0;
      hit_valid_q <= 1'b0;
      hit_ch_q    <= '0;
      // NOTE: the context array is an ordinary register file, not a RAM, and
      // must be cleared by reset so stale history can never produce a hit.
      for (int i = 0; i < N_CH; i++) ctx_q[i] <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      hit_valid_q <= hit_valid_d;
      hit_ch_q    <= hit_ch_d;
      for (int i = 0; i < N_CH; i++) ctx_q[i] <= ctx_d[i];
    end
  end

`ifdef HIT_CNT_EN
  logic [CNT_W-1:0] cnt_q [N_CH];

  // Saturating hit counters; only reset clears them, flush leaves them alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) cnt_q[i] <= '0;
    end else if (match && (cnt_q[gnt_idx] != '1)) begin
      cnt_q[gnt_idx] <= cnt_q[gnt_idx] + CNT_W'(1);
    end
  end

  assign cnt_out = cnt_q[cnt_sel];
`else
  logic unused_cnt_sel;
  assign unused_cnt_sel = ^cnt_sel;
  assign cnt_out        = '0;
`endif

endmodule
